// File: rtl/ccip_mmio_initiator_pkg.sv
// ccip_mmio_initiator_pkg: entry/CCI-P MMIO types and tid helpers shared by the MMIO initiator
package ccip_mmio_initiator_pkg;
    localparam logic [1:0] MMIO_LEN_8B = 2'b01;

    typedef enum logic {FREE = 1'b0, PENDING = 1'b1} t_entry_state;

    typedef struct packed {
        t_entry_state state;
        logic [7:0]   gen;
        logic [15:0]  age;
    } t_entry;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_mmio_hdr;

    typedef struct packed {
        t_ccip_mmio_hdr hdr;
        logic [63:0]    data;
        logic           rspValid;
        logic           mmioRdValid;
        logic           mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_hdr;

    typedef struct packed {
        t_ccip_c2_hdr hdr;
        logic         mmioRdValid;
        logic [63:0]  data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // generation bits that do not fit above the index are dropped, so gen wraps in the tid
    function automatic logic [8:0] make_tid(input logic [7:0] gen, input logic [3:0] idx, input int unsigned iw);
        return ({1'b0, gen} << iw) | {5'b0, idx};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/ccip_mmio_initiator_if.sv
// ccip_mmio_initiator_if: command stream in and response strobe out of the MMIO initiator
interface ccip_mmio_initiator_if #(parameter int NUM_TID = 4);
    localparam int IW = $clog2(NUM_TID);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [15:0]   cmd_addr;
    logic [63:0]   cmd_wdata;
    logic          rsp_valid;
    logic [IW-1:0] rsp_tag;
    logic [63:0]   rsp_data;
    logic          rsp_timeout;
    logic          rsp_err;

    modport master(
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_tag, rsp_data, rsp_timeout, rsp_err
    );

    modport slave(
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_tag, rsp_data, rsp_timeout, rsp_err
    );
endinterface

// File: rtl/ccip_mmio_tid_alloc.sv
// ccip_mmio_tid_alloc: combinational lowest-set-bit priority encoder over an entry bitmap
module ccip_mmio_tid_alloc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  free_vec,
    output logic [IW-1:0] idx,
    output logic          any_free
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (free_vec[i]) idx = IW'(i);
    end

    assign any_free = |free_vec;
endmodule

// File: rtl/ccip_mmio_initiator.sv
// ccip_mmio_initiator: CCI-P MMIO requester with TID tracking and timeouts; CCIP_MMIO_INITIATOR_STATS_EN adds counters
module ccip_mmio_initiator
    import ccip_mmio_initiator_pkg::*;
#(
    parameter int NUM_TID        = 4,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ccip_mmio_initiator_if.slave io,
    output t_if_ccip_Rx          cp2af_sRxPort,
    input  t_if_ccip_Tx          af2cp_sTxPort,
    output logic [31:0]          stat_rd,
    output logic [31:0]          stat_wr,
    output logic [31:0]          stat_timeout,
    output logic [31:0]          stat_stray
);
    localparam int IW = $clog2(NUM_TID);
    localparam int GW = 9 - IW;
    localparam logic [15:0] AGE_MAX = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] AGE_EXP = 16'(TIMEOUT_CYCLES - 1);

    t_entry         ent [NUM_TID];
    logic [NUM_TID-1:0] free_vec, exp_vec;
    logic [IW-1:0]  alloc_idx, exp_idx, c2_idx;
    logic [GW-1:0]  c2_gen;
    logic           any_free, any_exp, hit, accept, misal, rd_acc, wr_acc, err_req, to_sel;
    logic [3:0]     err_cnt;
    t_if_ccip_c0_Rx c0_n;

    assign c2_idx = af2cp_sTxPort.c2.hdr.tid[IW-1:0];
    assign c2_gen = af2cp_sTxPort.c2.hdr.tid[8:IW];
    // stored gen has already advanced past the one carried by the outstanding tid
    assign hit = af2cp_sTxPort.c2.mmioRdValid && ent[c2_idx].state == PENDING &&
                 c2_gen == GW'(ent[c2_idx].gen - 8'd1);

    always_comb begin
        free_vec = '0;
        exp_vec  = '0;
        for (int i = 0; i < NUM_TID; i++) begin
            free_vec[i] = ent[i].state == FREE || (hit && c2_idx == IW'(i));
            exp_vec[i]  = ent[i].state == PENDING && ent[i].age >= AGE_EXP && !(hit && c2_idx == IW'(i));
        end
    end

    ccip_mmio_tid_alloc #(.N(NUM_TID), .IW(IW)) u_alloc (.free_vec(free_vec), .idx(alloc_idx), .any_free(any_free));
    ccip_mmio_tid_alloc #(.N(NUM_TID), .IW(IW)) u_exp (.free_vec(exp_vec), .idx(exp_idx), .any_free(any_exp));

    assign io.cmd_ready = reset_n && (io.cmd_write || any_free);
    assign accept  = io.cmd_valid && io.cmd_ready;
    assign misal   = accept && io.cmd_addr[0];
    assign rd_acc  = accept && !io.cmd_write && !io.cmd_addr[0];
    assign wr_acc  = accept && io.cmd_write && !io.cmd_addr[0];
    // errors that lost the port to a matched response are held back in err_cnt
    assign err_req = misal || err_cnt != 4'd0;
    assign to_sel  = !hit && !err_req && any_exp;

    always_comb begin
        c0_n = '0;
        c0_n.mmioWrValid    = wr_acc;
        c0_n.mmioRdValid    = rd_acc;
        c0_n.hdr.address    = (wr_acc || rd_acc) ? io.cmd_addr : 16'd0;
        c0_n.hdr.length     = (wr_acc || rd_acc) ? MMIO_LEN_8B : 2'b00;
        c0_n.hdr.tid        = rd_acc ? make_tid(ent[alloc_idx].gen, 4'(alloc_idx), IW) : 9'd0;
        c0_n.data           = wr_acc ? io.cmd_wdata : 64'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TID; i++) ent[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TID; i++) begin
                if (rd_acc && alloc_idx == IW'(i))
                    ent[i] <= '{state: PENDING, gen: ent[i].gen + 8'd1, age: 16'd0};
                else if (free_vec[i] || (to_sel && exp_idx == IW'(i)))
                    ent[i].state <= FREE;
                else if (ent[i].state == PENDING && ent[i].age != AGE_MAX)
                    ent[i].age <= ent[i].age + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cp2af_sRxPort  <= '0;
            io.rsp_valid   <= 1'b0;
            io.rsp_tag     <= '0;
            io.rsp_data    <= 64'd0;
            io.rsp_timeout <= 1'b0;
            io.rsp_err     <= 1'b0;
            err_cnt        <= 4'd0;
        end else begin
            cp2af_sRxPort  <= '{c0TxAlmFull: 1'b0, c1TxAlmFull: 1'b0, c0: c0_n, c1: '0};
            io.rsp_valid   <= hit || err_req || to_sel;
            io.rsp_tag     <= hit ? c2_idx : to_sel ? exp_idx : '0;
            io.rsp_data    <= hit ? af2cp_sTxPort.c2.data : 64'd0;
            io.rsp_timeout <= to_sel;
            io.rsp_err     <= !hit && err_req;
            err_cnt        <= hit ? err_cnt + {3'b0, misal && err_cnt != 4'hf} :
                              (!misal && err_cnt != 4'd0) ? err_cnt - 4'd1 : err_cnt;
        end
    end

`ifdef CCIP_MMIO_INITIATOR_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_rd      <= 32'd0;
            stat_wr      <= 32'd0;
            stat_timeout <= 32'd0;
            stat_stray   <= 32'd0;
        end else begin
            stat_rd      <= sat_inc(stat_rd, rd_acc);
            stat_wr      <= sat_inc(stat_wr, wr_acc);
            stat_timeout <= sat_inc(stat_timeout, to_sel);
            stat_stray   <= sat_inc(stat_stray, af2cp_sTxPort.c2.mmioRdValid && !hit);
        end
    end
`else
    assign stat_rd      = 32'd0;
    assign stat_wr      = 32'd0;
    assign stat_timeout = 32'd0;
    assign stat_stray   = 32'd0;
`endif
endmodule

// File: tb/tb_ccip_mmio_initiator.sv
// tb_ccip_mmio_initiator: scoreboarded random and directed bench for the CCI-P MMIO initiator
module tb_ccip_mmio_initiator;
    import ccip_mmio_initiator_pkg::*;
    localparam int NT = 4;
    localparam int TO = 16;
`ifdef CCIP_MMIO_INITIATOR_STATS_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ccip_mmio_initiator_if #(.NUM_TID(NT)) io();
    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;
    logic [31:0] s_rd, s_wr, s_to, s_st;

    ccip_mmio_initiator #(.NUM_TID(NT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .io(io), .cp2af_sRxPort(rx), .af2cp_sTxPort(tx),
        .stat_rd(s_rd), .stat_wr(s_wr), .stat_timeout(s_to), .stat_stray(s_st)
    );

    typedef struct {int due; logic wr; logic [15:0] addr; logic [8:0] tid; logic [63:0] data;} c0_exp_t;
    typedef struct {int due; logic [1:0] tag; logic [63:0] data; logic to; logic err;} rsp_exp_t;
    typedef struct {int due; logic [8:0] tid; logic [63:0] data;} sched_t;

    c0_exp_t c0q[$];
    rsp_exp_t rq[$];
    sched_t sq[$];
    int tests = 0, fails = 0, cyc = 0;

    // reference model: which entries hold a read, when it was accepted, how many times allocated
    bit pend [NT];
    int acc_c [NT];
    int cnt [NT];
    int backlog, m_rd, m_wr, m_to, m_st;
    bit auto_rsp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    function automatic logic [8:0] tid_of(input int i);
        return 9'((cnt[i] - 1) * NT + i);
    endfunction

    task automatic mreset();
        for (int i = 0; i < NT; i++) begin
            pend[i] = 1'b0;
            cnt[i] = 0;
            acc_c[i] = 0;
        end
        backlog = 0; m_rd = 0; m_wr = 0; m_to = 0; m_st = 0;
        c0q.delete(); rq.delete(); sq.delete();
    endtask

    task automatic step(input logic v, input logic w, input logic [15:0] a, input logic [63:0] d,
                        input logic c2v, input logic [8:0] t, input logic [63:0] c2d, output logic acc_o);
        int ti, fi;
        bit hit, rdy, done;
        io.cmd_valid = v; io.cmd_write = w; io.cmd_addr = a; io.cmd_wdata = d;
        tx.c2.mmioRdValid = c2v; tx.c2.hdr.tid = t; tx.c2.data = c2d;
        #1;
        ti = int'(t) % NT;
        hit = c2v && pend[ti] && t == tid_of(ti);
        if (c2v && !hit) m_st++;
        fi = -1;
        for (int i = NT - 1; i >= 0; i--)
            if (!pend[i] || (hit && i == ti)) fi = i;
        rdy = w || fi >= 0;
        chk("cmd_ready", {63'b0, io.cmd_ready}, {63'b0, rdy});
        acc_o = v && rdy;
        done = hit;
        if (hit) begin
            pend[ti] = 1'b0;
            rq.push_back('{cyc + 1, 2'(ti), c2d, 1'b0, 1'b0});
        end
        if (acc_o && a[0]) backlog++;
        if (!done && backlog > 0) begin
            backlog--;
            rq.push_back('{cyc + 1, 2'd0, 64'd0, 1'b0, 1'b1});
            done = 1'b1;
        end
        for (int i = 0; i < NT; i++)
            if (!done && pend[i] && cyc - acc_c[i] >= TO) begin
                pend[i] = 1'b0;
                m_to++;
                rq.push_back('{cyc + 1, 2'(i), 64'd0, 1'b1, 1'b0});
                done = 1'b1;
            end
        if (acc_o && !a[0]) begin
            if (w) begin
                m_wr++;
                c0q.push_back('{cyc + 1, 1'b1, a, 9'd0, d});
            end else begin
                pend[fi] = 1'b1; acc_c[fi] = cyc; cnt[fi]++; m_rd++;
                c0q.push_back('{cyc + 1, 1'b0, a, tid_of(fi), 64'd0});
                if (auto_rsp && $urandom_range(9) < 8)
                    sq.push_back('{cyc + 2 + int'($urandom_range(19)), tid_of(fi), {$urandom, $urandom}});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, 1'b0, 16'd0, 64'd0, 1'b0, 9'd0, 64'd0, a);
    endtask

    task automatic chk_stats();
        chk("stat_rd", {32'd0, s_rd}, SE ? 64'(m_rd) : 64'd0);
        chk("stat_wr", {32'd0, s_wr}, SE ? 64'(m_wr) : 64'd0);
        chk("stat_timeout", {32'd0, s_to}, SE ? 64'(m_to) : 64'd0);
        chk("stat_stray", {32'd0, s_st}, SE ? 64'(m_st) : 64'd0);
    endtask

    task automatic chk_quiet(input string n);
        chk({n, "_rsp_valid"}, {63'b0, io.rsp_valid}, 64'd0);
        chk({n, "_rsp_data"}, io.rsp_data, 64'd0);
        chk({n, "_cmd_ready"}, {63'b0, io.cmd_ready}, 64'd0);
        chk({n, "_rx_zero"}, {63'b0, |rx}, 64'd0);
    endtask

    always @(negedge clk) begin
        rsp_exp_t re;
        c0_exp_t ce;
        if (reset_n) begin
            while (rq.size() > 0 && rq[0].due < cyc) begin
                tests++; fails++;
                $display("FAIL rsp_missing: nothing seen, expected response due at cycle %0d (now %0d)", rq[0].due, cyc);
                void'(rq.pop_front());
            end
            while (c0q.size() > 0 && c0q[0].due < cyc) begin
                tests++; fails++;
                $display("FAIL c0_missing: nothing seen, expected request due at cycle %0d (now %0d)", c0q[0].due, cyc);
                void'(c0q.pop_front());
            end
            if (io.rsp_valid) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: got tag %0d to=%b err=%b, expected no response (cycle %0d)",
                             io.rsp_tag, io.rsp_timeout, io.rsp_err, cyc);
                end else begin
                    re = rq.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(re.due));
                    chk("rsp_tag", {62'b0, io.rsp_tag}, {62'b0, re.tag});
                    chk("rsp_data", io.rsp_data, re.data);
                    chk("rsp_timeout", {63'b0, io.rsp_timeout}, {63'b0, re.to});
                    chk("rsp_err", {63'b0, io.rsp_err}, {63'b0, re.err});
                end
            end
            if (rx.c0.mmioWrValid || rx.c0.mmioRdValid) begin
                chk("c0_exclusive", {63'b0, rx.c0.mmioWrValid && rx.c0.mmioRdValid}, 64'd0);
                if (c0q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL c0_unexpected: got request addr %h, expected none (cycle %0d)", rx.c0.hdr.address, cyc);
                end else begin
                    ce = c0q.pop_front();
                    chk("c0_cycle", 64'(cyc), 64'(ce.due));
                    chk("c0_wr", {63'b0, rx.c0.mmioWrValid}, {63'b0, ce.wr});
                    chk("c0_addr", {48'b0, rx.c0.hdr.address}, {48'b0, ce.addr});
                    chk("c0_len", {62'b0, rx.c0.hdr.length}, 64'd1);
                    chk("c0_tid", {55'b0, rx.c0.hdr.tid}, {55'b0, ce.tid});
                    chk("c0_data", rx.c0.data, ce.data);
                end
            end
        end
    end

    initial begin
        logic a;
        logic [8:0] t;
        int j;
        io.cmd_valid = 1'b0; io.cmd_write = 1'b0; io.cmd_addr = 16'd0; io.cmd_wdata = 64'd0;
        tx = '0;
        mreset();
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk_stats();
        reset_n = 1'b1;
        idle(2);

        step(1'b1, 1'b1, 16'h0020, 64'hDEADBEEF_CAFEF00D, 1'b0, 9'd0, 64'd0, a);
        idle(3);

        step(1'b1, 1'b0, 16'h0020, 64'd0, 1'b0, 9'd0, 64'd0, a);
        t = tid_of(0);
        idle(3);
        step(1'b0, 1'b0, 16'd0, 64'd0, 1'b1, t, 64'h1234, a);
        idle(2);

        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b0, 16'(16'h0040 + 8 * k), 64'd0, 1'b0, 9'd0, 64'd0, a);
        a = 1'b0;
        for (int k = 0; k < 10 && !a; k++)
            step(1'b1, 1'b0, 16'h0060, 64'd0, k == 2, tid_of(1), 64'h5555_AAAA_0000_0001, a);
        tests++;
        if (!a) begin
            fails++;
            $display("FAIL fifth_read: got no acceptance, expected acceptance after entry 1 freed");
        end
        for (int i = 0; i < NT; i++)
            if (pend[i]) step(1'b0, 1'b0, 16'd0, 64'd0, 1'b1, tid_of(i), {$urandom, $urandom}, a);
        idle(3);

        step(1'b1, 1'b0, 16'h0080, 64'd0, 1'b0, 9'd0, 64'd0, a);
        t = tid_of(0);
        idle(TO + 4);
        step(1'b0, 1'b0, 16'd0, 64'd0, 1'b1, t, 64'hBAD, a);
        idle(2);

        step(1'b1, 1'b0, 16'h0021, 64'd0, 1'b0, 9'd0, 64'd0, a);
        idle(2);
        chk_stats();

        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 16'(16'h0100 + 8 * k), 64'd0, 1'b0, 9'd0, 64'd0, a);
        idle(1);
        reset_n = 1'b0;
        io.cmd_valid = 1'b0;
        mreset();
        #1;
        chk_quiet("async_reset");
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("held_reset");
        chk_stats();
        reset_n = 1'b1;
        step(1'b1, 1'b0, 16'h0200, 64'd0, 1'b0, 9'd0, 64'd0, a);
        idle(2);
        step(1'b0, 1'b0, 16'd0, 64'd0, 1'b1, tid_of(0), 64'h77, a);
        idle(2);

        auto_rsp = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic c2v;
            logic [8:0] c2t;
            c2v = 1'b0; c2t = 9'd0; j = -1;
            for (int q = 0; q < sq.size() && j < 0; q++)
                if (sq[q].due <= cyc) j = q;
            if (j >= 0) begin
                c2v = 1'b1; c2t = sq[j].tid;
                step($urandom_range(9) < 6, $urandom_range(9) < 4,
                     {16'($urandom) & 16'hFFFE} | 16'($urandom_range(19) == 0),
                     {$urandom, $urandom}, c2v, c2t, sq[j].data, a);
                sq.delete(j);
            end else begin
                c2v = $urandom_range(99) < 3;
                c2t = 9'($urandom);
                step($urandom_range(9) < 6, $urandom_range(9) < 4,
                     {16'($urandom) & 16'hFFFE} | 16'($urandom_range(19) == 0),
                     {$urandom, $urandom}, c2v, c2t, {$urandom, $urandom}, a);
            end
        end
        auto_rsp = 1'b0;
        sq.delete();
        idle(TO + 30);
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);
        chk("c0_queue_drained", 64'(c0q.size()), 64'd0);
        chk_stats();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
